// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline <-> hazard controller signal bundle
//
// Purpose: groups the ID/EX/MEM hazard inputs and the forward/enable/flush/
// counter outputs of pipeline_hazard_ctrl into one bundle.
// Modports:
//   slave  - the hazard controller (hazard inputs in, control outputs out)
//   master - the pipeline side (drives hazard inputs, receives controls)
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_usesRs;
  logic             id_usesRt;
  logic             id_shouldJumpOrBranch;
  logic             ex_shouldWriteRegister;
  logic [4:0]       ex_registerWriteAddress;
  logic             ex_isLoad;
  logic             mem_shouldWriteRegister;
  logic [4:0]       mem_registerWriteAddress;
  logic             mem_isLoad;
  logic             mem_accessReq;
  logic             MIO_ready;
  logic [1:0]       fwdRs;
  logic [1:0]       fwdRt;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_flush;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport slave (
    input  id_rs, id_rt, id_usesRs, id_usesRt, id_shouldJumpOrBranch,
    input  ex_shouldWriteRegister, ex_registerWriteAddress, ex_isLoad,
    input  mem_shouldWriteRegister, mem_registerWriteAddress, mem_isLoad,
    input  mem_accessReq, MIO_ready,
    output fwdRs, fwdRt, pc_en, if_id_en, id_ex_en, ex_mem_en,
    output if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout,
    output stall_count, flush_count
  );

  modport master (
    output id_rs, id_rt, id_usesRs, id_usesRt, id_shouldJumpOrBranch,
    output ex_shouldWriteRegister, ex_registerWriteAddress, ex_isLoad,
    output mem_shouldWriteRegister, mem_registerWriteAddress, mem_isLoad,
    output mem_accessReq, MIO_ready,
    input  fwdRs, fwdRt, pc_en, if_id_en, id_ex_en, ex_mem_en,
    input  if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout,
    input  stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/forward scheduler for the 5-stage pipeline
//
// Purpose: resolves load-use, taken branch/jump and memory-wait hazards,
// selects ID operand forwarding, and keeps saturating stall/flush counters.
// A memory wait longer than MEM_TIMEOUT-1 frozen cycles is force-released
// and latched in the sticky mem_timeout flag.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-low reset
//   bus  - pipeline_hazard_ctrl_if.slave: hazard inputs from ID/EX/MEM,
//          forward selects, register enables, flush strobes, counters
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WCW-1:0]   r_wait_cnt;
  logic [WCW-1:0]   w_wait_cnt_nxt;
  logic             r_mem_timeout;
  logic             w_timeout_set;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;

  logic w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt;
  logic w_force, w_mem_wait, w_load_use;
  logic w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en;
  logic w_if_id_flush, w_id_ex_flush, w_mem_wb_flush;
  logic w_stall, w_flush;

  function automatic logic src_match(input logic       uses,
                                     input logic [4:0] src,
                                     input logic       wr,
                                     input logic [4:0] dst);
    return uses && (src != 5'd0) && wr && (src == dst);
  endfunction

  // A matching EX load cannot supply data yet, so selection falls through
  // to MEM; the load-use stall covers that cycle anyway.
  function automatic logic [1:0] fwd_sel(input logic ex_hit,
                                         input logic ex_load,
                                         input logic mem_hit,
                                         input logic mem_load);
    if (ex_hit && !ex_load) return 2'b01;
    else if (mem_hit)       return mem_load ? 2'b11 : 2'b10;
    else                    return 2'b00;
  endfunction

  assign w_ex_rs  = src_match(bus.id_usesRs, bus.id_rs, bus.ex_shouldWriteRegister, bus.ex_registerWriteAddress);
  assign w_ex_rt  = src_match(bus.id_usesRt, bus.id_rt, bus.ex_shouldWriteRegister, bus.ex_registerWriteAddress);
  assign w_mem_rs = src_match(bus.id_usesRs, bus.id_rs, bus.mem_shouldWriteRegister, bus.mem_registerWriteAddress);
  assign w_mem_rt = src_match(bus.id_usesRt, bus.id_rt, bus.mem_shouldWriteRegister, bus.mem_registerWriteAddress);

  assign bus.fwdRs = fwd_sel(w_ex_rs, bus.ex_isLoad, w_mem_rs, bus.mem_isLoad);
  assign bus.fwdRt = fwd_sel(w_ex_rt, bus.ex_isLoad, w_mem_rt, bus.mem_isLoad);

  // The last allowed wait cycle is treated as if memory were ready.
  assign w_force    = (r_state == ST_MEM_WAIT) && (r_wait_cnt == WCW'(MEM_TIMEOUT - 1));
  assign w_mem_wait = bus.mem_accessReq & ~bus.MIO_ready & ~w_force;
  assign w_load_use = (w_ex_rs | w_ex_rt) & bus.ex_isLoad;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_timeout_set) begin
        r_mem_timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_timeout_set  = 1'b0;
    w_pc_en        = 1'b1;
    w_if_id_en     = 1'b1;
    w_id_ex_en     = 1'b1;
    w_ex_mem_en    = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_mem_wb_flush = 1'b0;

    // Hazard priority: memory wait freezes everything, then load-use,
    // then the branch flush (held back until any stall clears).
    if (w_mem_wait) begin
      w_pc_en        = 1'b0;
      w_if_id_en     = 1'b0;
      w_id_ex_en     = 1'b0;
      w_ex_mem_en    = 1'b0;
      w_mem_wb_flush = 1'b1;
    end else if (w_load_use) begin
      w_pc_en       = 1'b0;
      w_if_id_en    = 1'b0;
      w_id_ex_flush = 1'b1;
    end else if (bus.id_shouldJumpOrBranch) begin
      w_if_id_flush = 1'b1;
    end

    case (r_state)
      ST_RUN: begin
        if (w_mem_wait) begin
          w_state_nxt    = ST_MEM_WAIT;
          w_wait_cnt_nxt = WCW'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (!bus.mem_accessReq || bus.MIO_ready) begin
          w_state_nxt    = ST_RUN;
          w_wait_cnt_nxt = '0;
        end else if (w_force) begin
          w_state_nxt    = ST_RUN;
          w_wait_cnt_nxt = '0;
          w_timeout_set  = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WCW'(1);
        end
      end
      default: begin
        w_state_nxt    = ST_RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  assign w_stall = ~w_pc_en;
  assign w_flush = w_if_id_flush | w_id_ex_flush | w_mem_wb_flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
      if (w_flush && (r_flush_count != {CNT_W{1'b1}})) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
    end
  end

  assign bus.pc_en        = w_pc_en;
  assign bus.if_id_en     = w_if_id_en;
  assign bus.id_ex_en     = w_id_ex_en;
  assign bus.ex_mem_en    = w_ex_mem_en;
  assign bus.if_id_flush  = w_if_id_flush;
  assign bus.id_ex_flush  = w_id_ex_flush;
  assign bus.mem_wb_flush = w_mem_wb_flush;
  assign bus.mem_timeout  = r_mem_timeout;
  assign bus.stall_count  = r_stall_count;
  assign bus.flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int MT = 16;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt, br;
    logic       exw;
    logic [4:0] exa;
    logic       exl;
    logic       memw;
    logic [4:0] mema;
    logic       meml, macc, rdy, rstn;
  } in_t;

  typedef struct {
    logic [1:0]    frs, frt;
    logic          pc, ifid, idex, exmem, fifid, fidex, fmemwb, to;
    logic [CW-1:0] sc, fc;
  } out_t;

  typedef struct {
    in_t        i;
    logic [1:0] frs, frt;
    logic [6:0] ctl;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) hif();
  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(hif.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: consecutive frozen cycles so far, sticky timeout, counters.
  int   m_waited = 0;
  logic m_to     = 1'b0;
  int   m_stall  = 0;
  int   m_flush  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic in_t idle();
    in_t v;
    v = '{default: '0};
    v.rstn = 1'b1;
    return v;
  endfunction

  function automatic in_t mk(input int rs, input int rt, input logic urs, input logic urt,
                             input logic br, input logic exw, input int exa, input logic exl,
                             input logic memw, input int mema, input logic meml,
                             input logic macc, input logic rdy);
    in_t v;
    v = idle();
    v.rs = 5'(rs); v.rt = 5'(rt); v.urs = urs; v.urt = urt; v.br = br;
    v.exw = exw; v.exa = 5'(exa); v.exl = exl;
    v.memw = memw; v.mema = 5'(mema); v.meml = meml;
    v.macc = macc; v.rdy = rdy;
    return v;
  endfunction

  function automatic logic [1:0] ref_fwd(input in_t v, input logic uses, input logic [4:0] a);
    if (!uses || a == 0) return 2'd0;
    if (v.exw && v.exa == a && !v.exl) return 2'd1;
    if (v.memw && v.mema == a) return v.meml ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  function automatic out_t model_out(input in_t v);
    out_t o;
    logic frc, mw, lu;
    frc = (m_waited == MT - 1);
    mw  = v.macc && !v.rdy && !frc;
    lu  = v.exl && v.exw && ((v.urs && v.rs != 0 && v.rs == v.exa) ||
                             (v.urt && v.rt != 0 && v.rt == v.exa));
    o.frs    = ref_fwd(v, v.urs, v.rs);
    o.frt    = ref_fwd(v, v.urt, v.rt);
    o.pc     = !(mw || lu);
    o.ifid   = !(mw || lu);
    o.idex   = !mw;
    o.exmem  = !mw;
    o.fmemwb = mw;
    o.fidex  = lu && !mw;
    o.fifid  = v.br && !mw && !lu;
    o.to     = m_to;
    o.sc     = CW'(m_stall);
    o.fc     = CW'(m_flush);
    return o;
  endfunction

  task automatic model_step(input in_t v);
    out_t e;
    if (!v.rstn) begin
      m_waited = 0; m_to = 1'b0; m_stall = 0; m_flush = 0;
    end else begin
      e = model_out(v);
      if (m_waited == MT - 1 && v.macc && !v.rdy) m_to = 1'b1;
      if (!e.pc && m_stall < CMAX) m_stall++;
      if ((e.fifid || e.fidex || e.fmemwb) && m_flush < CMAX) m_flush++;
      m_waited = e.fmemwb ? m_waited + 1 : 0;
    end
  endtask

  task automatic drive(input in_t v);
    hif.id_rs = v.rs; hif.id_rt = v.rt;
    hif.id_usesRs = v.urs; hif.id_usesRt = v.urt;
    hif.id_shouldJumpOrBranch = v.br;
    hif.ex_shouldWriteRegister = v.exw; hif.ex_registerWriteAddress = v.exa; hif.ex_isLoad = v.exl;
    hif.mem_shouldWriteRegister = v.memw; hif.mem_registerWriteAddress = v.mema; hif.mem_isLoad = v.meml;
    hif.mem_accessReq = v.macc; hif.MIO_ready = v.rdy;
    rst = v.rstn;
  endtask

  function automatic out_t sample();
    out_t o;
    o.frs = hif.fwdRs; o.frt = hif.fwdRt;
    o.pc = hif.pc_en; o.ifid = hif.if_id_en; o.idex = hif.id_ex_en; o.exmem = hif.ex_mem_en;
    o.fifid = hif.if_id_flush; o.fidex = hif.id_ex_flush; o.fmemwb = hif.mem_wb_flush;
    o.to = hif.mem_timeout; o.sc = hif.stall_count; o.fc = hif.flush_count;
    return o;
  endfunction

  // One clock: drive at negedge, compare mid-low-phase, advance model after posedge.
  task automatic cycle(input in_t v, output out_t got);
    out_t e;
    @(negedge clk);
    drive(v);
    #1;
    e   = model_out(v);
    got = sample();
    chk("fwdRs", got.frs, e.frs);
    chk("fwdRt", got.frt, e.frt);
    chk("en", {got.pc, got.ifid, got.idex, got.exmem}, {e.pc, e.ifid, e.idex, e.exmem});
    chk("flush", {got.fifid, got.fidex, got.fmemwb}, {e.fifid, e.fidex, e.fmemwb});
    chk("mem_timeout", got.to, e.to);
    chk("stall_count", got.sc, e.sc);
    chk("flush_count", got.fc, e.fc);
    @(posedge clk);
    #1;
    model_step(v);
  endtask

  task automatic do_reset();
    out_t g;
    in_t  v;
    v = idle();
    v.rstn = 1'b0;
    cycle(v, g);
  endtask

  vec_t tbl[11];

  initial begin
    in_t  v;
    out_t g;
    logic slow;

    //             rs rt urs urt br exw exa exl memw mema meml macc rdy
    tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 2'b00, 2'b00, 7'b1111000};
    tbl[1]  = '{mk(0, 5, 0, 1, 0, 1, 5, 0, 1, 5, 0, 0, 0), 2'b00, 2'b01, 7'b1111000};
    tbl[2]  = '{mk(0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0), 2'b00, 2'b00, 7'b1111000};
    tbl[3]  = '{mk(7, 0, 1, 0, 0, 0, 0, 0, 1, 7, 1, 0, 0), 2'b11, 2'b00, 7'b1111000};
    tbl[4]  = '{mk(7, 0, 1, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0), 2'b10, 2'b00, 7'b1111000};
    tbl[5]  = '{mk(3, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0), 2'b00, 2'b00, 7'b1111000};
    tbl[6]  = '{mk(3, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0), 2'b00, 2'b00, 7'b1111000};
    tbl[7]  = '{mk(0, 9, 0, 1, 0, 1, 9, 1, 0, 0, 0, 0, 0), 2'b00, 2'b00, 7'b0011010};
    tbl[8]  = '{mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 2'b00, 2'b00, 7'b1111100};
    tbl[9]  = '{mk(0, 9, 0, 1, 1, 1, 9, 1, 0, 0, 0, 1, 0), 2'b00, 2'b00, 7'b0000001};
    tbl[10] = '{mk(4, 0, 1, 0, 1, 1, 4, 0, 1, 4, 1, 1, 1), 2'b01, 2'b00, 7'b1111100};

    // Initial reset without checks: DUT state is unknown before it.
    drive(idle());
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    cycle(idle(), g);
    chk("rst_en", {g.pc, g.ifid, g.idex, g.exmem}, 4'b1111);
    chk("rst_counts", {g.sc, g.fc, g.to}, '0);

    // Table vectors.
    for (int k = 0; k < 11; k++) begin
      cycle(tbl[k].i, g);
      chk("tbl_fwdRs", g.frs, tbl[k].frs);
      chk("tbl_fwdRt", g.frt, tbl[k].frt);
      chk("tbl_ctl", {g.pc, g.ifid, g.idex, g.exmem, g.fifid, g.fidex, g.fmemwb}, tbl[k].ctl);
    end

    // Load-use: one stall cycle, then MEM forwards the load data.
    do_reset();
    cycle(mk(2, 4, 1, 1, 0, 1, 2, 1, 0, 0, 0, 0, 0), g);
    chk("lu_stall", {g.pc, g.fidex}, 2'b01);
    cycle(mk(2, 4, 1, 1, 0, 0, 0, 0, 1, 2, 1, 0, 0), g);
    chk("lu_fwd11", g.frs, 2'b11);
    chk("lu_pc_en", g.pc, 1'b1);
    chk("lu_stall_count", g.sc, 1);

    // Memory wait: three frozen cycles, release on the fourth.
    for (int k = 1; k <= 4; k++) begin
      v = idle();
      v.macc = 1'b1;
      v.rdy  = (k == 4);
      cycle(v, g);
      chk("mw_frozen", {g.pc, g.exmem, g.fmemwb}, (k < 4) ? 3'b001 : 3'b110);
    end
    cycle(idle(), g);
    chk("mw_no_timeout", g.to, 1'b0);

    // Load-use plus branch: stall first, branch flush on the next cycle.
    do_reset();
    cycle(mk(2, 0, 1, 0, 1, 1, 2, 1, 0, 0, 0, 0, 0), g);
    chk("lub_stall", {g.pc, g.fifid, g.fidex}, 3'b001);
    cycle(mk(2, 0, 1, 0, 1, 0, 0, 0, 1, 2, 1, 0, 0), g);
    chk("lub_flush", {g.pc, g.fifid}, 2'b11);
    cycle(idle(), g);
    chk("lub_flush_count", g.fc, 2);

    // Timeout: ready held low, forced release, sticky flag.
    for (int k = 1; k <= MT; k++) begin
      v = idle();
      v.macc = 1'b1;
      cycle(v, g);
      if (k < MT) chk("to_frozen", {g.pc, g.fmemwb}, 2'b01);
      else        chk("to_release", {g.pc, g.exmem, g.fmemwb, g.to}, 4'b1100);
    end
    cycle(idle(), g);
    chk("to_flag", g.to, 1'b1);
    cycle(idle(), g);
    chk("to_sticky", g.to, 1'b1);

    // Reset in the middle of a wait (wait count 5).
    for (int k = 0; k < 5; k++) begin
      v = idle();
      v.macc = 1'b1;
      cycle(v, g);
    end
    v = idle();
    v.macc = 1'b1;
    v.rstn = 1'b0;
    cycle(v, g);
    cycle(idle(), g);
    chk("rw_en", {g.pc, g.ifid, g.idex, g.exmem}, 4'b1111);
    chk("rw_counts", {g.sc, g.fc, g.to}, '0);

    // Counter saturation.
    for (int k = 0; k < 300; k++) cycle(mk(0, 9, 0, 1, 0, 1, 9, 1, 0, 0, 0, 0, 0), g);
    cycle(idle(), g);
    chk("sat_stall", g.sc, CMAX);
    chk("sat_flush", g.fc, CMAX);
    do_reset();

    // Randomized traffic against the reference model.
    slow = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (n % 100 == 0) slow = ($urandom_range(0, 1) == 1);
      v.rs   = 5'($urandom_range(0, 3));
      v.rt   = 5'($urandom_range(0, 3));
      v.urs  = 1'($urandom_range(0, 1));
      v.urt  = 1'($urandom_range(0, 1));
      v.br   = ($urandom_range(0, 3) == 0);
      v.exw  = 1'($urandom_range(0, 1));
      v.exa  = 5'($urandom_range(0, 3));
      v.exl  = 1'($urandom_range(0, 1));
      v.memw = 1'($urandom_range(0, 1));
      v.mema = 5'($urandom_range(0, 3));
      v.meml = 1'($urandom_range(0, 1));
      v.macc = slow ? ($urandom_range(0, 29) != 0) : ($urandom_range(0, 2) == 0);
      v.rdy  = slow ? ($urandom_range(0, 19) == 0) : 1'($urandom_range(0, 1));
      v.rstn = ($urandom_range(0, 149) != 0);
      cycle(v, g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
